// File: rtl/pattern_deserializer.sv
// Serial-to-parallel receiver for 8-bit thermometer-code frames with a one-entry output buffer.
// Optional legality checking on ERR is enabled by defining PATTERN_CHECK_EN.
module pattern_deserializer #(
   parameter int FRAME_BITS = 8
) (
   input  logic                  CLK,
   input  logic                  CLEAR,
   input  logic                  DIN,
   input  logic                  EN,
   input  logic                  RDY,
   output logic                  VALID,
   output logic [FRAME_BITS-1:0] DATA,
   output logic [2:0]            S_OUT,
   output logic                  ERR,
   output logic                  OVERRUN,
   output logic [2:0]            BIT_CNT
);

   typedef enum logic {IDLE, RECV} rx_state_t;

   rx_state_t             rx_state;
   // Only bits 1..7 of the frame are ever needed again, so bit 0 is not kept.
   logic [FRAME_BITS-2:0] shift;
   logic [FRAME_BITS-1:0] frame_next;
   logic [2:0]            s_next;
   logic                  complete;
   logic                  load;

   assign frame_next = {DIN, shift};
   assign complete   = EN && (rx_state == RECV) && (BIT_CNT == 3'd7);
   assign load       = complete && (!VALID || RDY);

   always_comb begin
      s_next = 3'd0;
      for (int i = 0; i < FRAME_BITS; i++)
         if (frame_next[i]) s_next = i[2:0];
   end

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         rx_state <= IDLE;
         shift    <= '0;
         BIT_CNT  <= 3'd0;
         VALID    <= 1'b0;
         DATA     <= '0;
         S_OUT    <= 3'd0;
         OVERRUN  <= 1'b0;
      end else begin
         if (EN) begin
            shift   <= frame_next[FRAME_BITS-1:1];
            BIT_CNT <= BIT_CNT + 3'd1;
            case (rx_state)
               IDLE:    rx_state <= RECV;
               RECV:    if (BIT_CNT == 3'd7) rx_state <= IDLE;
               default: rx_state <= IDLE;
            endcase
         end
         if (load) begin
            VALID <= 1'b1;
            DATA  <= frame_next;
            S_OUT <= s_next;
         end else if (VALID && RDY) begin
            VALID <= 1'b0;
         end
         // A completed frame with nowhere to go is dropped and flagged until reset.
         if (complete && VALID && !RDY)
            OVERRUN <= 1'b1;
      end
   end

`ifdef PATTERN_CHECK_EN
   logic err_next;

   // Thermometer code: nonzero and value+1 is a power of two (0xFF wraps to 0).
   assign err_next = (frame_next == '0) ||
                     ((frame_next & (frame_next + 8'd1)) != '0);

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR)    ERR <= 1'b0;
      else if (load) ERR <= err_next;
   end
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_deserializer.sv
// Directed bench for pattern_deserializer: framing, decode, buffering, overrun, gaps, async reset.
module tb_pattern_deserializer;

   logic       CLK = 1'b0;
   logic       CLEAR, DIN, EN, RDY;
   logic       VALID, ERR, OVERRUN;
   logic [7:0] DATA;
   logic [2:0] S_OUT, BIT_CNT;

   int vectors = 0;
   int miscompares = 0;

`ifdef PATTERN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   pattern_deserializer #(.FRAME_BITS(8)) dut (
      .CLK(CLK), .CLEAR(CLEAR), .DIN(DIN), .EN(EN), .RDY(RDY),
      .VALID(VALID), .DATA(DATA), .S_OUT(S_OUT), .ERR(ERR),
      .OVERRUN(OVERRUN), .BIT_CNT(BIT_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the current inputs; returns 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         DIN = b[i];
         EN  = 1'b1;
         tick();
      end
      EN = 1'b0;
   endtask

   task automatic consume();
      RDY = 1'b1;
      tick();
      RDY = 1'b0;
   endtask

   initial begin
      CLEAR = 1'b0; DIN = 1'b0; EN = 1'b0; RDY = 1'b0;
      #12;
      chk("rst_valid", {7'd0, VALID}, 8'h00);
      chk("rst_data", DATA, 8'h00);
      chk("rst_sout", {5'd0, S_OUT}, 8'h00);
      chk("rst_err", {7'd0, ERR}, 8'h00);
      chk("rst_ovr", {7'd0, OVERRUN}, 8'h00);
      chk("rst_cnt", {5'd0, BIT_CNT}, 8'h00);
      CLEAR = 1'b1;
      tick();

      // 0x0F: partial count, then zero-latency load
      send_bits(8'h0F, 0, 6);
      chk("0f_cnt7", {5'd0, BIT_CNT}, 8'h07);
      chk("0f_novalid", {7'd0, VALID}, 8'h00);
      send_bits(8'h0F, 7, 7);
      chk("0f_valid", {7'd0, VALID}, 8'h01);
      chk("0f_data", DATA, 8'h0F);
      chk("0f_sout", {5'd0, S_OUT}, 8'h03);
      chk("0f_err", {7'd0, ERR}, 8'h00);
      chk("0f_cnt", {5'd0, BIT_CNT}, 8'h00);
      consume();
      chk("0f_consumed", {7'd0, VALID}, 8'h00);
      chk("0f_data_hold", DATA, 8'h0F);

      // 0x05 is illegal
      send_bits(8'h05, 0, 7);
      chk("05_data", DATA, 8'h05);
      chk("05_sout", {5'd0, S_OUT}, 8'h02);
      chk("05_err", {7'd0, ERR}, {7'd0, CHK});
      consume();

      // 0x00: S_OUT 0, illegal when checking
      send_bits(8'h00, 0, 7);
      chk("00_valid", {7'd0, VALID}, 8'h01);
      chk("00_sout", {5'd0, S_OUT}, 8'h00);
      chk("00_err", {7'd0, ERR}, {7'd0, CHK});
      consume();

      // 0x3F with a 3-cycle enable gap after 4 bits
      send_bits(8'h3F, 0, 3);
      for (int g = 0; g < 3; g++) begin
         DIN = ~DIN;
         tick();
         chk("3f_gap_cnt", {5'd0, BIT_CNT}, 8'h04);
      end
      send_bits(8'h3F, 4, 7);
      chk("3f_data", DATA, 8'h3F);
      chk("3f_sout", {5'd0, S_OUT}, 8'h05);
      chk("3f_err", {7'd0, ERR}, 8'h00);
      consume();

      // 0x03 held; 0x7F completes on the consume edge
      send_bits(8'h03, 0, 7);
      chk("03_data", DATA, 8'h03);
      send_bits(8'h7F, 0, 6);
      chk("03_still", DATA, 8'h03);
      RDY = 1'b1;
      send_bits(8'h7F, 7, 7);
      RDY = 1'b0;
      chk("7f_valid", {7'd0, VALID}, 8'h01);
      chk("7f_data", DATA, 8'h7F);
      chk("7f_sout", {5'd0, S_OUT}, 8'h06);
      chk("7f_ovr", {7'd0, OVERRUN}, 8'h00);
      consume();

      // 0xFF held, 0x01 dropped -> overrun
      send_bits(8'hFF, 0, 7);
      send_bits(8'h01, 0, 7);
      chk("ff_valid", {7'd0, VALID}, 8'h01);
      chk("ff_data", DATA, 8'hFF);
      chk("ff_sout", {5'd0, S_OUT}, 8'h07);
      chk("ff_err", {7'd0, ERR}, 8'h00);
      chk("ff_ovr", {7'd0, OVERRUN}, 8'h01);
      consume();
      chk("ff_consumed", {7'd0, VALID}, 8'h00);
      chk("ff_ovr_sticky", {7'd0, OVERRUN}, 8'h01);

      // Async reset mid-frame, away from the clock edge
      send_bits(8'h1F, 0, 3);
      #2 CLEAR = 1'b0;
      #1;
      chk("ar_cnt", {5'd0, BIT_CNT}, 8'h00);
      chk("ar_data", DATA, 8'h00);
      chk("ar_ovr", {7'd0, OVERRUN}, 8'h00);
      chk("ar_sout", {5'd0, S_OUT}, 8'h00);
      tick();
      #2 CLEAR = 1'b1;
      send_bits(8'h1F, 0, 7);
      chk("1f_valid", {7'd0, VALID}, 8'h01);
      chk("1f_data", DATA, 8'h1F);
      chk("1f_sout", {5'd0, S_OUT}, 8'h04);
      chk("1f_err", {7'd0, ERR}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pattern_deserializer.md
PATTERN_DESERIALIZER -- requirements
Module: pattern_deserializer

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 8, bits per frame; only 8 is supported.
REQ-002 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLEAR  in  1  asynchronous active-low reset.
REQ-004 SHALL have port DIN  in  1  serial data, LSB of frame first.
REQ-005 SHALL have port EN  in  1  sample enable; DIN is sampled only on edges where EN=1.
REQ-006 SHALL have port RDY  in  1  consumer ready for the held frame.
REQ-007 SHALL have port VALID  out  1  held frame available.
REQ-008 SHALL have port DATA  out  8  held frame, bit i = i-th bit received.
REQ-009 SHALL have port S_OUT  out  3  decoded pattern index of DATA.
REQ-010 SHALL have port ERR  out  1  DATA is not a legal pattern (see REQ-024).
REQ-011 SHALL have port OVERRUN  out  1  sticky frame-dropped flag.
REQ-012 SHALL have port BIT_CNT  out  3  number of bits of the current frame received so far.

Function
REQ-013 Receive FSM SHALL have states IDLE (BIT_CNT=0) and RECV (BIT_CNT 1..7).
REQ-014 On an edge with EN=1: shift register <= {DIN, shift[7:1]}; BIT_CNT increments mod 8.
REQ-015 IDLE->RECV on an edge with EN=1; RECV->IDLE on the edge sampling bit 7 (BIT_CNT=7, EN=1).
REQ-016 On an edge with EN=0, the shift register, BIT_CNT and FSM state SHALL hold; gaps of any length SHALL NOT corrupt the frame.
REQ-017 Frame completion SHALL be the edge sampling bit 7; the complete byte is {DIN, shift[7:1]}.
REQ-018 Output buffer SHALL be one entry; states EMPTY (VALID=0) and FULL (VALID=1).
REQ-019 On completion with buffer EMPTY, DATA/S_OUT/ERR SHALL load and VALID SHALL rise on that same edge (zero-cycle latency after the 8th sample).
REQ-020 On an edge with VALID=1 and RDY=1, the frame SHALL be consumed and VALID SHALL clear, unless a frame completes on the same edge.
REQ-021 Simultaneous consume and completion SHALL load the new frame and keep VALID=1; OVERRUN SHALL NOT set.
REQ-022 On completion with VALID=1 and RDY=0, the new frame SHALL be discarded, DATA/S_OUT/ERR SHALL hold, and OVERRUN SHALL set.
REQ-023 OVERRUN SHALL remain set until reset.
REQ-024 Legal patterns SHALL be the thermometer codes 0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF; their S_OUT SHALL be 0..7 respectively.
REQ-025 S_OUT SHALL be the index of the highest set bit of DATA, or 0 for DATA=0x00.
REQ-026 DATA, S_OUT and ERR SHALL change only on a load edge; they are registered outputs.

Reset
REQ-027 CLEAR=0 SHALL immediately, independent of CLK, force: FSM IDLE, BIT_CNT=0, shift=0x00, buffer EMPTY, VALID=0, DATA=0x00, S_OUT=0, ERR=0, OVERRUN=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first EN=1 edge after CLEAR rises SHALL sample bit 0 of a new frame.

Configuration
REQ-029 Macro PATTERN_CHECK_EN SHALL control legality checking.
REQ-030 With PATTERN_CHECK_EN defined: ERR SHALL load 1 for any DATA outside the REQ-024 set, including 0x00, and 0 otherwise.
REQ-031 Without PATTERN_CHECK_EN: ERR SHALL be constant 0, with no checking logic; S_OUT SHALL still follow REQ-025.

Verification
REQ-032 Reset, EN=1, DIN=1,1,1,1,0,0,0,0 -> after 8th edge VALID=1, DATA=0x0F, S_OUT=3, ERR=0, BIT_CNT=0.
REQ-033 DIN frame 1,0,1,0,0,0,0,0 (0x05), macro defined -> DATA=0x05, S_OUT=2, ERR=1; same stimulus, macro undefined -> ERR=0.
REQ-034 0xFF frame, RDY=0, then 0x01 frame -> VALID=1, DATA=0xFF, S_OUT=7, OVERRUN=1; then RDY=1 for one edge -> VALID=0, OVERRUN stays 1.
REQ-035 0x3F frame with EN=0 for 3 cycles after bit 4 -> BIT_CNT holds at 4 during the gap; DATA=0x3F, S_OUT=5 on completion.
REQ-036 RDY=1 on the edge a 0x7F frame completes while 0x03 is held -> VALID stays 1, DATA=0x7F, S_OUT=6, OVERRUN=0.
REQ-037 CLEAR=0 asynchronously after 4 bits -> all outputs 0 at once; next 8 EN edges of 0x1F -> DATA=0x1F, S_OUT=4.
